// File: rtl/pipe_pkg.sv
// Shared constants for the processor pipeline latch banks.
//   PIPE_WIDTH    : default width of every IR/PC/data word
//   PIPE_NOP_WORD : all-zero instruction used for reset and bubbles
//   *_WORDS       : number of words carried by each bank
//   IDX_*         : word slot of each field inside a bank
package pipe_pkg;

    localparam int unsigned PIPE_WIDTH = 32;

    localparam logic [PIPE_WIDTH-1:0] PIPE_NOP_WORD = 32'h0000_0000;

    localparam int unsigned FD_WORDS = 2;
    localparam int unsigned DX_WORDS = 4;
    localparam int unsigned MW_WORDS = 4;

    // IR always lives in slot 0 so the latch can bubble it without knowing the bank type
    localparam int unsigned IDX_IR = 0;
    localparam int unsigned IDX_PC = 1;
    localparam int unsigned IDX_A  = 2;
    localparam int unsigned IDX_B  = 3;
    localparam int unsigned IDX_O  = 2;
    localparam int unsigned IDX_D  = 3;

endpackage

// File: rtl/stage_latch.sv
// N-word pipeline latch with load enable, bubble flush and sync active-low reset.
//   i_clk    : clock, updates on rising edge
//   i_rst_n  : synchronous active-low reset; word 0 <- NOP_WORD, others <- 0
//   i_en     : load enable; when low every word holds and i_flush is ignored
//   i_flush  : with i_en high, word 0 loads NOP_WORD instead of its input
//   i_words  : input words, word 0 is the instruction word
//   o_words  : registered words
module stage_latch
    import pipe_pkg::*;
#(
    parameter int unsigned          N_WORDS  = 2,
    parameter int unsigned          WIDTH    = PIPE_WIDTH,
    parameter logic [WIDTH-1:0]     NOP_WORD = WIDTH'(PIPE_NOP_WORD)
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_en,
    input  logic                            i_flush,
    input  logic [N_WORDS-1:0][WIDTH-1:0]   i_words,
    output logic [N_WORDS-1:0][WIDTH-1:0]   o_words
);

    logic [N_WORDS-1:0][WIDTH-1:0] r_words;

    // Reset beats enable; enable gates both the load and the flush
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_words    <= '0;
            r_words[0] <= NOP_WORD;
        end else if (i_en) begin
            r_words <= i_words;
            if (i_flush) begin
                r_words[0] <= NOP_WORD;
            end
        end
    end

    assign o_words = r_words;

endmodule

// File: rtl/pipe_stage_regs.sv
// FD, DX and MW pipeline latch banks of the five-stage processor.
// The parent feeds the inverted processor clock, so these latches update mid-cycle.
//   clock                : rising-edge clock for all banks
//   reset                : synchronous active-low reset of all banks
//   fd_en / fd_flush     : FD load enable / bubble request
//   fd_ir_in, fd_pc_in   : fetched instruction and next PC
//   fd_*_out             : registered FD contents
//   dx_en / dx_flush     : DX load enable / bubble request
//   dx_{ir,pc,a,b}_in    : decoded IR, PC, regfile A/B data
//   dx_*_out             : registered DX contents
//   mw_en / mw_flush     : MW load enable / bubble request
//   mw_{ir,pc,o,d}_in    : IR, PC, ALU result, dmem read data
//   mw_*_out             : registered MW contents
module pipe_stage_regs
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH    = PIPE_WIDTH,
    parameter logic [WIDTH-1:0] NOP_WORD = WIDTH'(PIPE_NOP_WORD)
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             fd_en,
    input  logic             fd_flush,
    input  logic [WIDTH-1:0] fd_ir_in,
    input  logic [WIDTH-1:0] fd_pc_in,
    output logic [WIDTH-1:0] fd_ir_out,
    output logic [WIDTH-1:0] fd_pc_out,

    input  logic             dx_en,
    input  logic             dx_flush,
    input  logic [WIDTH-1:0] dx_ir_in,
    input  logic [WIDTH-1:0] dx_pc_in,
    input  logic [WIDTH-1:0] dx_a_in,
    input  logic [WIDTH-1:0] dx_b_in,
    output logic [WIDTH-1:0] dx_ir_out,
    output logic [WIDTH-1:0] dx_pc_out,
    output logic [WIDTH-1:0] dx_a_out,
    output logic [WIDTH-1:0] dx_b_out,

    input  logic             mw_en,
    input  logic             mw_flush,
    input  logic [WIDTH-1:0] mw_ir_in,
    input  logic [WIDTH-1:0] mw_pc_in,
    input  logic [WIDTH-1:0] mw_o_in,
    input  logic [WIDTH-1:0] mw_d_in,
    output logic [WIDTH-1:0] mw_ir_out,
    output logic [WIDTH-1:0] mw_pc_out,
    output logic [WIDTH-1:0] mw_o_out,
    output logic [WIDTH-1:0] mw_d_out
);

    logic [FD_WORDS-1:0][WIDTH-1:0] w_fd_d;
    logic [FD_WORDS-1:0][WIDTH-1:0] w_fd_q;
    logic [DX_WORDS-1:0][WIDTH-1:0] w_dx_d;
    logic [DX_WORDS-1:0][WIDTH-1:0] w_dx_q;
    logic [MW_WORDS-1:0][WIDTH-1:0] w_mw_d;
    logic [MW_WORDS-1:0][WIDTH-1:0] w_mw_q;

    // FD bank: IR, PC
    assign w_fd_d[IDX_IR] = fd_ir_in;
    assign w_fd_d[IDX_PC] = fd_pc_in;

    stage_latch #(
        .N_WORDS  (FD_WORDS),
        .WIDTH    (WIDTH),
        .NOP_WORD (NOP_WORD)
    ) u_fd (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_en    (fd_en),
        .i_flush (fd_flush),
        .i_words (w_fd_d),
        .o_words (w_fd_q)
    );

    assign fd_ir_out = w_fd_q[IDX_IR];
    assign fd_pc_out = w_fd_q[IDX_PC];

    // DX bank: IR, PC, operand A, operand B
    assign w_dx_d[IDX_IR] = dx_ir_in;
    assign w_dx_d[IDX_PC] = dx_pc_in;
    assign w_dx_d[IDX_A]  = dx_a_in;
    assign w_dx_d[IDX_B]  = dx_b_in;

    stage_latch #(
        .N_WORDS  (DX_WORDS),
        .WIDTH    (WIDTH),
        .NOP_WORD (NOP_WORD)
    ) u_dx (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_en    (dx_en),
        .i_flush (dx_flush),
        .i_words (w_dx_d),
        .o_words (w_dx_q)
    );

    assign dx_ir_out = w_dx_q[IDX_IR];
    assign dx_pc_out = w_dx_q[IDX_PC];
    assign dx_a_out  = w_dx_q[IDX_A];
    assign dx_b_out  = w_dx_q[IDX_B];

    // MW bank: IR, PC, ALU result, memory data
    assign w_mw_d[IDX_IR] = mw_ir_in;
    assign w_mw_d[IDX_PC] = mw_pc_in;
    assign w_mw_d[IDX_O]  = mw_o_in;
    assign w_mw_d[IDX_D]  = mw_d_in;

    stage_latch #(
        .N_WORDS  (MW_WORDS),
        .WIDTH    (WIDTH),
        .NOP_WORD (NOP_WORD)
    ) u_mw (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_en    (mw_en),
        .i_flush (mw_flush),
        .i_words (w_mw_d),
        .o_words (w_mw_q)
    );

    assign mw_ir_out = w_mw_q[IDX_IR];
    assign mw_pc_out = w_mw_q[IDX_PC];
    assign mw_o_out  = w_mw_q[IDX_O];
    assign mw_d_out  = w_mw_q[IDX_D];

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Self-checking bench for pipe_stage_regs: directed vector table, then a random
// phase checked against a reference model through an expected-value queue.
module tb_pipe_stage_regs;

    typedef struct packed {
        logic [31:0] fd_ir;
        logic [31:0] fd_pc;
        logic [31:0] dx_ir;
        logic [31:0] dx_pc;
        logic [31:0] dx_a;
        logic [31:0] dx_b;
        logic [31:0] mw_ir;
        logic [31:0] mw_pc;
        logic [31:0] mw_o;
        logic [31:0] mw_d;
    } bus_t;

    // en/flush bit 0 = FD, bit 1 = DX, bit 2 = MW
    typedef struct packed {
        logic       rst_n;
        logic [2:0] en;
        logic [2:0] flush;
        bus_t       din;
        bus_t       exp;
    } vec_t;

    localparam int NVEC = 12;
    localparam logic [31:0] F = 32'hFFFF_FFFF;
    localparam logic [31:0] Z = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        fd_en, fd_flush, dx_en, dx_flush, mw_en, mw_flush;
    logic [31:0] fd_ir_in, fd_pc_in, fd_ir_out, fd_pc_out;
    logic [31:0] dx_ir_in, dx_pc_in, dx_a_in, dx_b_in;
    logic [31:0] dx_ir_out, dx_pc_out, dx_a_out, dx_b_out;
    logic [31:0] mw_ir_in, mw_pc_in, mw_o_in, mw_d_in;
    logic [31:0] mw_ir_out, mw_pc_out, mw_o_out, mw_d_out;

    int n_assert = 0;
    int n_fail   = 0;

    vec_t  tbl [NVEC];
    string tnames [NVEC];
    bus_t  exp_q [$];
    string tag_q [$];
    bus_t  model;
    string fnames [10];

    always #5 clock = ~clock;

    pipe_stage_regs #(
        .WIDTH    (32),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .fd_en     (fd_en),
        .fd_flush  (fd_flush),
        .fd_ir_in  (fd_ir_in),
        .fd_pc_in  (fd_pc_in),
        .fd_ir_out (fd_ir_out),
        .fd_pc_out (fd_pc_out),
        .dx_en     (dx_en),
        .dx_flush  (dx_flush),
        .dx_ir_in  (dx_ir_in),
        .dx_pc_in  (dx_pc_in),
        .dx_a_in   (dx_a_in),
        .dx_b_in   (dx_b_in),
        .dx_ir_out (dx_ir_out),
        .dx_pc_out (dx_pc_out),
        .dx_a_out  (dx_a_out),
        .dx_b_out  (dx_b_out),
        .mw_en     (mw_en),
        .mw_flush  (mw_flush),
        .mw_ir_in  (mw_ir_in),
        .mw_pc_in  (mw_pc_in),
        .mw_o_in   (mw_o_in),
        .mw_d_in   (mw_d_in),
        .mw_ir_out (mw_ir_out),
        .mw_pc_out (mw_pc_out),
        .mw_o_out  (mw_o_out),
        .mw_d_out  (mw_d_out)
    );

    function automatic bus_t mk_bus(input logic [31:0] a0, a1, a2, a3, a4,
                                    input logic [31:0] a5, a6, a7, a8, a9);
        bus_t b;
        b.fd_ir = a0; b.fd_pc = a1;
        b.dx_ir = a2; b.dx_pc = a3; b.dx_a = a4; b.dx_b = a5;
        b.mw_ir = a6; b.mw_pc = a7; b.mw_o = a8; b.mw_d = a9;
        return b;
    endfunction

    function automatic vec_t mk_vec(input logic r, input logic [2:0] e,
                                    input logic [2:0] f, input bus_t d, input bus_t x);
        vec_t v;
        v.rst_n = r; v.en = e; v.flush = f; v.din = d; v.exp = x;
        return v;
    endfunction

    function automatic bus_t dut_out();
        return mk_bus(fd_ir_out, fd_pc_out, dx_ir_out, dx_pc_out, dx_a_out,
                      dx_b_out, mw_ir_out, mw_pc_out, mw_o_out, mw_d_out);
    endfunction

    // Reference behaviour of one edge: reset > hold > bubble > load, per bank
    function automatic bus_t model_step(input bus_t m, input vec_t v);
        bus_t n = m;
        if (!v.rst_n) begin
            n = '0;
        end else begin
            if (v.en[0]) begin
                n.fd_ir = v.flush[0] ? Z : v.din.fd_ir;
                n.fd_pc = v.din.fd_pc;
            end
            if (v.en[1]) begin
                n.dx_ir = v.flush[1] ? Z : v.din.dx_ir;
                n.dx_pc = v.din.dx_pc;
                n.dx_a  = v.din.dx_a;
                n.dx_b  = v.din.dx_b;
            end
            if (v.en[2]) begin
                n.mw_ir = v.flush[2] ? Z : v.din.mw_ir;
                n.mw_pc = v.din.mw_pc;
                n.mw_o  = v.din.mw_o;
                n.mw_d  = v.din.mw_d;
            end
        end
        return n;
    endfunction

    task automatic drive(input vec_t v);
        reset    = v.rst_n;
        fd_en    = v.en[0];    fd_flush = v.flush[0];
        dx_en    = v.en[1];    dx_flush = v.flush[1];
        mw_en    = v.en[2];    mw_flush = v.flush[2];
        fd_ir_in = v.din.fd_ir; fd_pc_in = v.din.fd_pc;
        dx_ir_in = v.din.dx_ir; dx_pc_in = v.din.dx_pc;
        dx_a_in  = v.din.dx_a;  dx_b_in  = v.din.dx_b;
        mw_ir_in = v.din.mw_ir; mw_pc_in = v.din.mw_pc;
        mw_o_in  = v.din.mw_o;  mw_d_in  = v.din.mw_d;
    endtask

    // Compare every output word against the oldest queued expectation
    task automatic check_head();
        bus_t  e;
        bus_t  a;
        string t;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL scoreboard: output sampled with empty expected queue");
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = dut_out();
        for (int k = 0; k < 10; k++) begin
            n_assert++;
            if (a[k*32 +: 32] !== e[k*32 +: 32]) begin
                n_fail++;
                $display("FAIL %s.%s got %h expected %h", t, fnames[k],
                         a[k*32 +: 32], e[k*32 +: 32]);
            end
        end
    endtask

    // Drive at negedge, latch at posedge, sample at the following negedge
    task automatic run_vec(input string tag, input vec_t v);
        drive(v);
        exp_q.push_back(v.exp);
        tag_q.push_back(tag);
        @(posedge clock);
        @(negedge clock);
        check_head();
    endtask

    initial begin
        vec_t  v;
        bus_t  d;
        bus_t  e5;
        bus_t  e8;
        bus_t  e10;

        fnames = '{"mw_d", "mw_o", "mw_pc", "mw_ir", "dx_b", "dx_a",
                   "dx_pc", "dx_ir", "fd_pc", "fd_ir"};

        e5  = mk_bus(32'h0800_0003, 32'd4, Z, 32'd12, 32'd5, 32'd3,
                     32'h4000_0000, 32'd20, 32'd100, 32'h1234_5678);
        e8  = mk_bus(32'hAAAA_0001, 32'h10, 32'hBBBB_0002, 32'h20, 32'h21, 32'h22,
                     32'hCCCC_0003, 32'h30, 32'h31, 32'h32);
        e10 = mk_bus(Z, 32'h14, 32'h5555_0000, 32'h18, 32'hA, 32'hB,
                     Z, 32'h1C, 32'hC, 32'hD);

        tnames[0]  = "reset";
        tbl[0]     = mk_vec(1'b0, 3'b111, 3'b000, mk_bus(F, F, F, F, F, F, F, F, F, F), '0);
        tnames[1]  = "fd_load";
        tbl[1]     = mk_vec(1'b1, 3'b001, 3'b000,
                            mk_bus(32'h2800_0005, 32'd7, F, F, F, F, F, F, F, F),
                            mk_bus(32'h2800_0005, 32'd7, Z, Z, Z, Z, Z, Z, Z, Z));
        tnames[2]  = "fd_hold";
        tbl[2]     = mk_vec(1'b1, 3'b000, 3'b000,
                            mk_bus(32'hDEAD_BEEF, 32'd9, F, F, F, F, F, F, F, F),
                            mk_bus(32'h2800_0005, 32'd7, Z, Z, Z, Z, Z, Z, Z, Z));
        tnames[3]  = "dx_flush";
        tbl[3]     = mk_vec(1'b1, 3'b010, 3'b010,
                            mk_bus(F, F, 32'h0042_0001, 32'd12, 32'd5, 32'd3, F, F, F, F),
                            mk_bus(32'h2800_0005, 32'd7, Z, 32'd12, 32'd5, 32'd3, Z, Z, Z, Z));
        tnames[4]  = "mw_capture";
        tbl[4]     = mk_vec(1'b1, 3'b100, 3'b000,
                            mk_bus(F, F, F, F, F, F, 32'h4000_0000, 32'd20, 32'd100, 32'h1234_5678),
                            mk_bus(32'h2800_0005, 32'd7, Z, 32'd12, 32'd5, 32'd3,
                                   32'h4000_0000, 32'd20, 32'd100, 32'h1234_5678));
        tnames[5]  = "fd_load2";
        tbl[5]     = mk_vec(1'b1, 3'b001, 3'b000,
                            mk_bus(32'h0800_0003, 32'd4, F, F, F, F, F, F, F, F), e5);
        tnames[6]  = "flush_under_hold";
        tbl[6]     = mk_vec(1'b1, 3'b000, 3'b001,
                            mk_bus(32'h1111_1111, 32'h99, F, F, F, F, F, F, F, F), e5);
        tnames[7]  = "midrun_reset";
        tbl[7]     = mk_vec(1'b0, 3'b000, 3'b000, mk_bus(F, F, F, F, F, F, F, F, F, F), '0);
        tnames[8]  = "post_reset_load";
        tbl[8]     = mk_vec(1'b1, 3'b111, 3'b000, e8, e8);
        tnames[9]  = "x_under_hold";
        tbl[9]     = mk_vec(1'b1, 3'b000, 3'b111, 'x, e8);
        tnames[10] = "multi_flush";
        tbl[10]    = mk_vec(1'b1, 3'b111, 3'b101,
                            mk_bus(32'h1234_0001, 32'h14, 32'h5555_0000, 32'h18, 32'hA, 32'hB,
                                   32'h6666_0000, 32'h1C, 32'hC, 32'hD), e10);
        tnames[11] = "indep_banks";
        tbl[11]    = mk_vec(1'b1, 3'b001, 3'b010,
                            mk_bus(32'h7777_0000, 32'h30, F, F, F, F, F, F, F, F),
                            mk_bus(32'h7777_0000, 32'h30, 32'h5555_0000, 32'h18, 32'hA, 32'hB,
                                   Z, 32'h1C, 32'hC, 32'hD));

        drive(tbl[0]);
        @(negedge clock);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(tnames[i], tbl[i]);
        end

        // Random phase: disabled banks see X inputs, occasional reset pulses
        model = tbl[NVEC-1].exp;
        for (int i = 0; i < 400; i++) begin
            d = mk_bus($urandom, $urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom, $urandom);
            v.rst_n = ($urandom_range(0, 15) != 0);
            v.en    = 3'($urandom);
            v.flush = 3'($urandom);
            if (!v.en[0]) begin d.fd_ir = 'x; d.fd_pc = 'x; end
            if (!v.en[1]) begin d.dx_ir = 'x; d.dx_pc = 'x; d.dx_a = 'x; d.dx_b = 'x; end
            if (!v.en[2]) begin d.mw_ir = 'x; d.mw_pc = 'x; d.mw_o = 'x; d.mw_d = 'x; end
            v.din = d;
            v.exp = model_step(model, v);
            model = v.exp;
            run_vec("random", v);
        end

        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
